// File: rtl/sig_synth_n.sv
// Period synthesizer: takes a clk-count N that spans M signal periods and produces a square wave
// whose M consecutive periods total exactly N clk cycles. The remainder is spread with an error accumulator.
module sig_synth_n #(
  parameter int CLK_COUNTER_SIZE = 14,
  parameter int M                = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [CLK_COUNTER_SIZE-1:0] n_clk_in,
  output logic                        sig,
  output logic                        frame_start,
  output logic                        busy,
  output logic                        err
);

  localparam int W  = CLK_COUNTER_SIZE;
  localparam int AW = $clog2(M) + 1;
  localparam int PW = $clog2(M);
  localparam int CW = $clog2(W + 1);
  localparam logic [AW-1:0] M_A   = AW'(M);
  localparam logic [W:0]    TWO_M = (W + 1)'(2 * M);
  localparam logic [PW-1:0] LAST  = PW'(M - 1);

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} dstate_t;
  typedef enum logic [1:0] {G_IDLE, G_HIGH, G_LOW} gstate_t;

  dstate_t         dstate_q, dstate_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [W-1:0]    nval_q, nval_d;
  logic            busy_q, busy_d;

  gstate_t         gstate_q, gstate_d;
  logic            sig_q, sig_d;
  logic            fs_q, fs_d;
  logic            err_q, err_d;
  logic [W-1:0]    qa_q, qa_d;
  logic [AW-1:0]   ra_q, ra_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    low_q, low_d;
  logic [PW-1:0]   per_q, per_d;

  logic            pend, pend_valid, pend_err, adopt;
  logic [AW-1:0]   trial;

  // Restoring division: quo_q starts as the dividend and shifts quotient bits in from the right.
  always_comb begin
    dstate_d = dstate_q;
    dcnt_d   = dcnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    nval_d   = nval_q;
    busy_d   = (dstate_q == D_BUSY) && (dcnt_q != '0);
    trial    = {rem_q[AW-2:0], quo_q[W-1]};
    if (load) begin
      dstate_d = D_BUSY;
      dcnt_d   = CW'(W);
      quo_d    = n_clk_in;
      rem_d    = '0;
      nval_d   = n_clk_in;
    end else begin
      case (dstate_q)
        D_BUSY: begin
          if (dcnt_q != '0) begin
            if (trial >= M_A) begin
              rem_d = trial - M_A;
              quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
              rem_d = trial;
              quo_d = {quo_q[W-2:0], 1'b0};
            end
            dcnt_d = dcnt_q - CW'(1);
          end else begin
            dstate_d = D_DONE;
          end
        end
        D_DONE:  if (adopt) dstate_d = D_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    logic          start, new_frame;
    logic [W-1:0]  src_q, p, h;
    logic [AW-1:0] src_r, src_acc, s;

    pend       = (dstate_q == D_DONE);
    pend_valid = ({1'b0, nval_q} >= TWO_M);
    pend_err   = (nval_q != '0) && !pend_valid;
    adopt      = 1'b0;
    start      = 1'b0;
    new_frame  = 1'b0;
    src_q      = qa_q;
    src_r      = ra_q;
    src_acc    = acc_q;
    s          = '0;
    p          = '0;
    h          = '0;
    gstate_d   = gstate_q;
    sig_d      = sig_q;
    fs_d       = 1'b0;
    err_d      = err_q;
    qa_d       = qa_q;
    ra_d       = ra_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    low_d      = low_q;
    per_d      = per_q;

    case (gstate_q)
      G_IDLE: begin
        sig_d = 1'b0;
        if (pend) adopt = 1'b1;
      end
      G_HIGH: begin
        if (cnt_q == '0) begin
          gstate_d = G_LOW;
          sig_d    = 1'b0;
          cnt_d    = low_q - W'(1);
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      G_LOW: begin
        if (cnt_q == '0) begin
          if (per_q == LAST) begin
            if (pend) adopt = 1'b1;
            else begin
              start     = 1'b1;
              new_frame = 1'b1;
            end
          end else begin
            start = 1'b1;
            per_d = per_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      default: gstate_d = G_IDLE;
    endcase

    if (adopt) begin
      err_d = pend_err;
      qa_d  = quo_q;
      ra_d  = rem_q;
      if (pend_valid) begin
        start     = 1'b1;
        new_frame = 1'b1;
        src_q     = quo_q;
        src_r     = rem_q;
        src_acc   = '0;
      end else begin
        gstate_d = G_IDLE;
        sig_d    = 1'b0;
      end
    end

    if (new_frame) begin
      per_d = '0;
      fs_d  = 1'b1;
    end

    // The accumulator sum is compared before subtracting so it never wraps.
    if (start) begin
      s = src_acc + src_r;
      if (s >= M_A) begin
        p     = src_q + W'(1);
        acc_d = s - M_A;
      end else begin
        p     = src_q;
        acc_d = s;
      end
      h        = p >> 1;
      cnt_d    = h - W'(1);
      low_d    = p - h;
      sig_d    = 1'b1;
      gstate_d = G_HIGH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dstate_q <= D_IDLE;
      dcnt_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      nval_q   <= '0;
      busy_q   <= 1'b0;
      gstate_q <= G_IDLE;
      sig_q    <= 1'b0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
      qa_q     <= '0;
      ra_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      low_q    <= '0;
      per_q    <= '0;
    end else begin
      dstate_q <= dstate_d;
      dcnt_q   <= dcnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      nval_q   <= nval_d;
      busy_q   <= busy_d;
      gstate_q <= gstate_d;
      sig_q    <= sig_d;
      fs_q     <= fs_d;
      err_q    <= err_d;
      qa_q     <= qa_d;
      ra_q     <= ra_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      low_q    <= low_d;
      per_q    <= per_d;
    end
  end

  assign sig         = sig_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sig_synth_n.sv
// Bench for sig_synth_n: a frame-level model (closed-form period lengths, load/adoption timeline)
// is compared against the DUT every cycle, plus directed literal timing checks.
module tb_sig_synth_n;
  localparam int W  = 14;
  localparam int MM = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] n_clk_in = '0;
  logic         sig, frame_start, busy, err;

  sig_synth_n #(.CLK_COUNTER_SIZE(W), .M(MM)) dut (
    .clk(clk), .reset(reset), .load(load), .n_clk_in(n_clk_in),
    .sig(sig), .frame_start(frame_start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, edge_n = 0;

  bit m_running, m_err, m_pend, m_div_active;
  int m_pend_n, m_div_n, m_div_start, m_n_act, m_cyc;
  bit m_pat [0:16383];
  bit exp_sig, exp_fs, exp_busy, exp_err;

  bit prev_sig = 1'b0;
  int rise_count = 0, last_rise = -1, last_period = -1, prev_period = -1, last_high = -1;
  int fs_count = 0, last_fs = -1, fs_interval = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Period j of a frame is q plus the step in floor(j*r/M).
  function automatic void build_frame(input int n);
    int q, r, pos, p;
    q = n / MM;
    r = n % MM;
    pos = 0;
    for (int j = 0; j < MM; j++) begin
      p = q + ((j + 1) * r) / MM - (j * r) / MM;
      for (int k = 0; k < p; k++) m_pat[pos + k] = (k < p / 2);
      pos += p;
    end
  endfunction

  function automatic void adopt(input int n);
    m_err = (n != 0) && (n < 2 * MM);
    if (n >= 2 * MM) begin
      m_running = 1'b1;
      m_n_act   = n;
      m_cyc     = 0;
      build_frame(n);
    end else begin
      m_running = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit rst, input bit ld, input int n);
    bit pend_pre, consumed;
    if (rst) begin
      m_running = 0; m_err = 0; m_pend = 0; m_div_active = 0; m_cyc = 0;
      exp_sig = 0; exp_fs = 0; exp_busy = 0; exp_err = 0;
      return;
    end
    pend_pre = m_pend;
    consumed = 1'b0;
    exp_busy = m_div_active && (edge_n - m_div_start >= 1) && (edge_n - m_div_start <= W);
    if (m_running) begin
      m_cyc++;
      if (m_cyc == m_n_act) begin
        if (pend_pre) begin
          adopt(m_pend_n);
          consumed = 1'b1;
        end else begin
          m_cyc = 0;
        end
      end
    end else if (pend_pre) begin
      adopt(m_pend_n);
      consumed = 1'b1;
    end
    if (ld) begin
      m_div_active = 1'b1;
      m_div_n      = n;
      m_div_start  = edge_n;
      m_pend       = 1'b0;
    end else if (consumed) begin
      m_pend = 1'b0;
    end else if (m_div_active && edge_n == m_div_start + W + 1) begin
      m_pend       = 1'b1;
      m_pend_n     = m_div_n;
      m_div_active = 1'b0;
    end
    exp_sig = m_running && m_pat[m_cyc];
    exp_fs  = m_running && (m_cyc == 0);
    exp_err = m_err;
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge(reset, load, int'(n_clk_in));
    @(negedge clk);
    check("sig", int'(sig), int'(exp_sig));
    check("frame_start", int'(frame_start), int'(exp_fs));
    check("busy", int'(busy), int'(exp_busy));
    check("err", int'(err), int'(exp_err));
    if (sig && !prev_sig) begin
      rise_count++;
      prev_period = last_period;
      if (last_rise >= 0) last_period = edge_n - last_rise;
      last_rise = edge_n;
    end
    if (!sig && prev_sig) last_high = edge_n - last_rise;
    if (frame_start) begin
      fs_count++;
      if (last_fs >= 0) fs_interval = edge_n - last_fs;
      last_fs = edge_n;
    end
    prev_sig = sig;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int n, output int at);
    load = 1'b1;
    n_clk_in = W'(n);
    step();
    load = 1'b0;
    at = edge_n;
  endtask

  task automatic wait_rise(input int bound, output int at);
    int c0, i;
    c0 = rise_count;
    i = 0;
    while (rise_count == c0 && i < bound) begin step(); i++; end
    at = last_rise;
    if (rise_count == c0) begin
      tests++; fails++;
      $display("FAIL wait_rise: no rise within %0d cycles, required one", bound);
    end
  endtask

  task automatic wait_fs(input int bound);
    int c0, i;
    c0 = fs_count;
    i = 0;
    while (fs_count == c0 && i < bound) begin step(); i++; end
    if (fs_count == c0) begin
      tests++; fails++;
      $display("FAIL wait_fs: no frame_start within %0d cycles, required one", bound);
    end
  endtask

  initial begin
    int t, r, bc, rc0, sel, n, gap;

    run(3);
    reset = 1'b0;
    step();
    check("rst_sig", int'(sig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_fs", int'(frame_start), 0);

    // Exact division
    do_load(4000, t);
    step();
    check("busy_after_load", int'(busy), 1);
    wait_rise(40, r);
    check("first_rise_latency", r - t, 16);
    run(500);
    check("period_4000", last_period, 80);
    check("high_4000", last_high, 40);
    wait_fs(4100);
    check("frame_4000", fs_interval, 4000);
    check("err_4000", int'(err), 0);

    // Mid-frame reload
    run(1000);
    do_load(5000, t);
    run(1000);
    check("old_period_kept", last_period, 80);
    wait_fs(4000);
    check("old_frame_len", fs_interval, 4000);
    run(250);
    check("period_5000", last_period, 100);
    wait_fs(5100);
    check("frame_5000", fs_interval, 5000);

    // Remainder distribution
    do_load(4025, t);
    wait_fs(5100);
    check("frame_before_4025", fs_interval, 5000);
    run(170);
    check("period0_4025", prev_period, 80);
    check("period1_4025", last_period, 81);
    wait_fs(4100);
    check("frame_4025", fs_interval, 4025);

    // Invalid / stop / minimum valid
    do_load(99, t);
    run(4100);
    check("err_99", int'(err), 1);
    check("sig_99", int'(sig), 0);
    do_load(0, t);
    run(20);
    check("err_0", int'(err), 0);
    check("sig_0", int'(sig), 0);
    do_load(100, t);
    wait_rise(40, r);
    check("latency_100", r - t, 16);
    run(10);
    check("period_100", last_period, 2);
    check("high_100", last_high, 1);

    // Back-to-back loads
    do_load(6000, t);
    run(4);
    do_load(4500, t);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) bc++;
    end
    check("busy_cycles", bc, 14);
    wait_fs(300);
    run(200);
    check("period_4500", last_period, 90);

    // Reset during the high phase with a division in flight
    rc0 = rise_count;
    for (int i = 0; i < 200 && rise_count == rc0; i++) step();
    do_load(3000, t);
    step();
    check("busy_before_reset", int'(busy), 1);
    check("high_before_reset", int'(sig), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_sig", int'(sig), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);
    rc0 = rise_count;
    run(300);
    check("no_rise_after_reset", rise_count - rc0, 0);

    // Randomized loads, gaps and resets
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 4) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        if (sel < 9) n = 0;
        else if (sel < 19) n = int'($urandom_range(1, 99));
        else n = int'($urandom_range(100, 1500));
        do_load(n, t);
      end
      if ($urandom_range(0, 4) == 0) gap = int'($urandom_range(0, 20));
      else gap = int'($urandom_range(0, 1500));
      run(gap);
    end
    run(3200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
